bht_port_scheduler: RTL and testbench
=====================================

# bht_port_scheduler

Sequencer and arbiter for a single-ported 2-bit branch history table (BHT) in the IF stage. It time-shares the one table port between three requesters: the post-reset/clear initialiser, IF-stage prediction lookups, and queued ID-stage outcome updates. Updates are buffered in a small FIFO, and a starvation guard keeps the queue draining. The block owns the table, computes saturating counter updates, and returns the prediction one cycle after each accepted lookup.

## Interface
- TABLESIZE, 128, BHT entries
- INDEXBITS, 7, index width; index = pc[INDEXBITS+1:2]
- FIFO_DEPTH, 4, update queue depth (power of two)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before it forces a drain slot
- INIT_CTR, 2'b01, counter value written to every entry during init

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  one-cycle pulse: re-initialise the table and flush the FIFO
- lookup_valid  in  1  IF requests a prediction
- lookup_pc  in  32  PC of the fetched branch
- lookup_ready  out  1  lookup accepted this cycle when high with lookup_valid
- pred_valid  out  1  prediction data valid
- pred_taken  out  1  pred_ctr[1]
- pred_ctr  out  2  counter read; IF/ID carries it to ID
- upd_valid  in  1  resolved branch outcome
- upd_pc  in  32  PC of the resolved branch
- upd_ctr  in  2  counter value returned by that branch's lookup
- upd_taken  in  1  actual outcome
- upd_ready  out  1  FIFO can accept
- init_busy  out  1  init sweep in progress
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued updates

## Operation
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Update: taken gives min(ctr+1,3); not taken gives max(ctr-1,0). The new value is computed from upd_ctr at enqueue, and the FIFO stores {index, new_ctr}.
- FSM states:
  - S_INIT: one port write per cycle of INIT_CTR to init_idx. init_idx runs 0..TABLESIZE-1, then the FSM goes to S_RUN.
  - S_RUN: normal arbitration.
- Port priority per cycle in S_RUN:
  - A forced drain comes first. A drain is forced when the FIFO is full, or when head_wait ≥ STARVE_LIMIT. On a forced drain, lookup_ready = 0.
  - Otherwise an accepted lookup (read) takes the port.
  - Otherwise, if the FIFO is non-empty, the head is written.
- head_wait: counts cycles the current head has been present without being written. It resets to 0 on every pop and saturates at STARVE_LIMIT.
- lookup_ready = (state==S_RUN) && !force_drain. It is combinational from registered state only and does not depend on lookup_valid.
- upd_ready = (state==S_RUN) && (fifo_level < FIFO_DEPTH). There is no same-cycle push-while-full bypass. Simultaneous push and pop is allowed; the level is unchanged.
- Pending updates are not forwarded to lookups. A lookup returns table contents as of its read cycle.
- clear is sampled in S_RUN or S_INIT. The next cycle enters S_INIT with init_idx = 0 and the FIFO emptied.
  - A lookup accepted in the clear cycle still returns its data.
  - An update accepted in the clear cycle is discarded.
- rst mid-operation: everything returns to reset state immediately, and the init sweep restarts at index 0 once reset is released.

## Timing
- Reset values:
  - lookup_ready 0, upd_ready 0, pred_valid 0, pred_taken 0, pred_ctr 2'b00, fifo_level 0, init_busy 1.
  - Internally: state S_INIT, init_idx 0, head_wait 0.
- Init sweep: the first write happens in the first clk edge after rst falls. It takes exactly TABLESIZE cycles. lookup_ready and upd_ready rise in cycle TABLESIZE+1 (relative to rst deassertion). init_busy falls at the same time.
- Lookup accepted at edge t: pred_valid = 1 with data during t+1. pred_valid is low in any cycle with no lookup accepted in the previous cycle. pred_ctr holds its last value when pred_valid is low.
- Update enqueued at t: earliest table write is at t+1. A lookup to the same index accepted at t+2 or later sees the new value.
- Drain starvation bound: the head is written no later than STARVE_LIMIT+1 cycles after it reaches the head.

## Structure
- Package bp_sched_pkg holds:
  - counter encodings (SNT/WNT/WT/ST localparams);
  - the sat_update(ctr, taken) function;
  - FSM state encoding;
  - the BEQ/BNE opcodes, shared with the rest of the predictor logic.
- Sub-module bht_sp_ram: single-port synchronous-read TABLESIZE×2 array with one addr/we/wdata/rdata port. It has no reset; initialisation is done by the sweep.
- The FIFO is inline: head/tail pointers plus a level counter.

## Test plan
- Reset release: sample 10 random indices once init_busy=0 → all read 2'b01. lookup_ready rises exactly TABLESIZE+1 cycles after rst falls.
- Lookup then update, index 5:
  - Lookup returns ctr 01.
  - Enqueue upd_taken=1 with ctr 01, then a lookup 2 cycles later → pred_ctr 10, pred_taken 1.
  - Two more taken updates → 11 (saturates).
- Continuous lookup_valid every cycle, then 3 updates pushed → lookup_ready drops for exactly one cycle per entry, each at STARVE_LIMIT (8) cycles of head wait. fifo_level returns to 0.
- 4 updates back-to-back under a continuous lookup stream → upd_ready = 0 while full. The forced drain takes the next cycle. A 5th update is accepted one cycle after the pop.
- clear pulsed with 2 queued updates and a lookup in flight:
  - pred_valid asserts the next cycle.
  - fifo_level goes to 0 and the queued updates are never written.
  - After TABLESIZE cycles all entries read 01.
- rst asserted mid-sweep at init_idx 60 → outputs take reset values asynchronously, and the sweep restarts from index 0.

Source files
------------

// File: rtl/bht_port_scheduler_pkg.sv
// Shared types and helpers for the BHT port scheduler: counter encodings,
// saturating update, FSM states and the branch opcodes used across the predictor.
package bp_sched_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sched_state_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_port_scheduler_if.sv
// Lookup, prediction, update and status signals between the IF/ID pipeline
// (master) and the BHT port scheduler (slave).
interface bht_port_scheduler_if #(
  parameter int FIFO_DEPTH = 4
) ();

  logic                          clear;
  logic                          lookup_valid;
  logic [31:0]                   lookup_pc;
  logic                          lookup_ready;
  logic                          pred_valid;
  logic                          pred_taken;
  logic [1:0]                    pred_ctr;
  logic                          upd_valid;
  logic [31:0]                   upd_pc;
  logic [1:0]                    upd_ctr;
  logic                          upd_taken;
  logic                          upd_ready;
  logic                          init_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output clear, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ctr, upd_taken,
    input  lookup_ready, pred_valid, pred_taken, pred_ctr, upd_ready, init_busy, fifo_level
  );

  modport slave (
    input  clear, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ctr, upd_taken,
    output lookup_ready, pred_valid, pred_taken, pred_ctr, upd_ready, init_busy, fifo_level
  );

endinterface

// File: rtl/bht_port_scheduler_ram.sv
// Single-port synchronous-read counter table; contents are established by the
// scheduler's init sweep rather than by reset.
module bht_sp_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [1:0]    wdata,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; a reset here would turn the array
  // into flops and is redundant because the sweep writes every entry.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bht_port_scheduler.sv
// Time-shares the single BHT port between the init sweep, IF lookups and the
// queued ID updates, with a starvation guard that forces the queue to drain.
module bht_port_scheduler
  import bp_sched_pkg::*;
#(
  parameter int         TABLESIZE    = 128,
  parameter int         INDEXBITS    = 7,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         STARVE_LIMIT = 8,
  parameter logic [1:0] INIT_CTR     = CTR_WNT
) (
  input logic                 clk,
  input logic                 rst,
  bht_port_scheduler_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [INDEXBITS-1:0] idx;
    logic [1:0]           ctr;
  } upd_entry_t;

  sched_state_t         state, state_nxt;
  logic [INDEXBITS-1:0] init_idx;
  upd_entry_t           fifo_mem [FIFO_DEPTH];
  upd_entry_t           head_entry;
  logic [PTR_W-1:0]     head, tail;
  logic [LVL_W-1:0]     level;
  logic [WAIT_W-1:0]    head_wait;
  logic                 in_run, fifo_empty, fifo_full, force_drain;
  logic                 lookup_ready, upd_ready, lookup_fire, push, pop;
  logic                 pred_valid_q;
  logic [1:0]           last_ctr;
  logic [INDEXBITS-1:0] lookup_idx, ram_addr;
  logic                 ram_we;
  logic [1:0]           ram_wdata, ram_rdata;
  logic                 unused_pc_bits;

  assign lookup_idx  = bus.lookup_pc[INDEXBITS+1:2];
  assign head_entry  = fifo_mem[head];
  assign in_run      = (state == S_RUN);
  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == LVL_W'(FIFO_DEPTH));
  assign force_drain = !fifo_empty && (fifo_full || head_wait >= WAIT_W'(STARVE_LIMIT));

  // Ready signals come from registered state only, never from the valids.
  assign lookup_ready = in_run && !force_drain;
  assign upd_ready    = in_run && !fifo_full;
  assign lookup_fire  = bus.lookup_valid && lookup_ready;
  assign push         = bus.upd_valid && upd_ready && !bus.clear;
  assign pop          = in_run && !bus.clear && !fifo_empty && !lookup_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = lookup_idx;
    ram_wdata = INIT_CTR;
    case (state)
      S_INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_idx;
        if (init_idx == INDEXBITS'(TABLESIZE - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (pop) begin
          ram_we    = 1'b1;
          ram_addr  = head_entry.idx;
          ram_wdata = head_entry.ctr;
        end
      end
      default: ;
    endcase
    if (bus.clear) state_nxt = S_INIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  init_idx <= '0;
    else if (bus.clear)       init_idx <= '0;
    else if (state == S_INIT) init_idx <= (init_idx == INDEXBITS'(TABLESIZE - 1)) ? '0
                                                                                    : init_idx + INDEXBITS'(1);
  end

  // Clear flushes the queue, so updates queued (or offered) at that point never reach the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      head_wait <= '0;
    end else if (bus.clear) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      head_wait <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
      if (pop || fifo_empty)                          head_wait <= '0;
      else if (head_wait != WAIT_W'(STARVE_LIMIT))    head_wait <= head_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= '{idx: bus.upd_pc[INDEXBITS+1:2],
                                  ctr: sat_update(bus.upd_ctr, bus.upd_taken)};
  end

  // pred_ctr holds the last delivered value while no prediction is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      last_ctr     <= CTR_SNT;
    end else begin
      pred_valid_q <= lookup_fire;
      if (pred_valid_q) last_ctr <= ram_rdata;
    end
  end

  bht_sp_ram #(.DEPTH(TABLESIZE), .AW(INDEXBITS)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.lookup_ready = lookup_ready;
  assign bus.upd_ready    = upd_ready;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_ctr     = pred_valid_q ? ram_rdata : last_ctr;
  assign bus.pred_taken   = bus.pred_ctr[1];
  assign bus.init_busy    = (state == S_INIT);
  assign bus.fifo_level   = level;

  assign unused_pc_bits = ^{bus.lookup_pc[31:INDEXBITS+2], bus.lookup_pc[1:0],
                            bus.upd_pc[31:INDEXBITS+2], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Self-checking bench for bht_port_scheduler: directed scenarios plus random
// traffic, all compared against a queue/array model of the arbitration rules.
module tb_bht_port_scheduler;

  localparam int TS    = 128;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bht_port_scheduler_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  bht_port_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Reference model: table array, update queue, head wait count, sweep progress.
  typedef struct {
    int idx;
    int ctr;
  } m_upd_t;

  m_upd_t m_q[$];
  int     m_tbl[TS];
  bit     m_run;
  int     m_init;
  int     m_wait;
  bit     m_pv;
  int     m_pctr;

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic [31:0] pc_of(input int idx);
    return ($urandom & 32'hFFFF_FE03) | (32'(idx) << 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_run  = 1'b0;
    m_init = 0;
    m_wait = 0;
    m_pv   = 1'b0;
    m_pctr = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit cl, input bit lv, input logic [31:0] lpc,
                            input bit uv, input logic [31:0] upc, input int uctr, input bit ut);
    int     n;
    bit     frc, lr, ur, lfire, pop, push;
    m_upd_t h;
    n     = m_q.size();
    frc   = (n > 0) && (n == DEPTH || m_wait >= LIMIT);
    lr    = m_run && !frc;
    ur    = m_run && (n < DEPTH);
    lfire = lv && lr;
    pop   = m_run && !cl && (n > 0) && !lfire;
    push  = uv && ur && !cl;
    m_pv  = lfire;
    if (lfire) m_pctr = m_tbl[int'((lpc >> 2) % TS)];
    if (!m_run) begin
      m_tbl[m_init] = 1;
      m_init++;
      if (m_init == TS) m_run = 1'b1;
    end
    if (pop) begin
      h = m_q.pop_front();
      m_tbl[h.idx] = h.ctr;
    end
    if (pop || n == 0) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
    if (push) m_q.push_back('{int'((upc >> 2) % TS), sat(uctr, ut)});
    if (cl) begin
      m_q.delete();
      m_wait = 0;
      m_run  = 1'b0;
      m_init = 0;
    end
  endtask

  task automatic check_all();
    int n;
    bit frc;
    n   = m_q.size();
    frc = (n > 0) && (n == DEPTH || m_wait >= LIMIT);
    check("lookup_ready", ifc.lookup_ready, m_run && !frc);
    check("upd_ready",    ifc.upd_ready,    m_run && (n < DEPTH));
    check("init_busy",    ifc.init_busy,    !m_run);
    check("fifo_level",   ifc.fifo_level,   n);
    check("pred_valid",   ifc.pred_valid,   m_pv);
    check("pred_ctr",     ifc.pred_ctr,     m_pctr);
    check("pred_taken",   ifc.pred_taken,   m_pctr >> 1);
  endtask

  task automatic step(input bit cl, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input logic [1:0] uctr, input bit ut);
    ifc.clear        = cl;
    ifc.lookup_valid = lv;
    ifc.lookup_pc    = lpc;
    ifc.upd_valid    = uv;
    ifc.upd_pc       = upc;
    ifc.upd_ctr      = uctr;
    ifc.upd_taken    = ut;
    model_step(cl, lv, lpc, uv, upc, int'(uctr), ut);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic lookup(input int idx);
    step(1'b0, 1'b1, pc_of(idx), 1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic update(input int idx, input logic [1:0] c, input bit t);
    step(1'b0, 1'b0, 32'h0, 1'b1, pc_of(idx), c, t);
  endtask

  // Counts edges until lookup_ready rises; an expired bound shows up as a wrong count.
  task automatic wait_run(input string tag);
    int k;
    for (k = 1; k <= TS + 20; k++) begin
      idle();
      if (ifc.lookup_ready === 1'b1) break;
    end
    check(tag, k, TS);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lookup_ready"}, ifc.lookup_ready, 0);
    check({tag, "_upd_ready"},    ifc.upd_ready,    0);
    check({tag, "_pred_valid"},   ifc.pred_valid,   0);
    check({tag, "_pred_taken"},   ifc.pred_taken,   0);
    check({tag, "_pred_ctr"},     ifc.pred_ctr,     0);
    check({tag, "_fifo_level"},   ifc.fifo_level,   0);
    check({tag, "_init_busy"},    ifc.init_busy,    1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] drop_mask;
    rst              = 1'b1;
    ifc.clear        = 1'b0;
    ifc.lookup_valid = 1'b0;
    ifc.lookup_pc    = 32'h0;
    ifc.upd_valid    = 1'b0;
    ifc.upd_pc       = 32'h0;
    ifc.upd_ctr      = 2'b00;
    ifc.upd_taken    = 1'b0;
    for (int i = 0; i < TS; i++) m_tbl[i] = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_run("init_len");

    for (int i = 0; i < 10; i++) begin
      lookup($urandom_range(0, TS - 1));
      check("init_val", ifc.pred_ctr, 1);
    end

    // Index 5: read, one taken update, then saturate.
    lookup(5);
    check("idx5_first", ifc.pred_ctr, 1);
    update(5, 2'b01, 1'b1);
    idle();
    lookup(5);
    check("idx5_after_taken", ifc.pred_ctr, 2);
    check("idx5_pred_taken", ifc.pred_taken, 1);
    update(5, 2'b10, 1'b1);
    idle();
    update(5, 2'b11, 1'b1);
    idle();
    lookup(5);
    check("idx5_saturate", ifc.pred_ctr, 3);

    // Continuous lookups starve three queued updates; each forces one drain slot.
    drop_mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (ifc.lookup_ready !== 1'b1) drop_mask[i] = 1'b1;
      step(1'b0, 1'b1, pc_of($urandom_range(0, TS - 1)), i < 3,
           pc_of($urandom_range(40, 47)), 2'($urandom), 1'($urandom));
    end
    check("starve_drops", drop_mask, (32'd1 << 9) | (32'd1 << 18) | (32'd1 << 27));
    check("starve_level", ifc.fifo_level, 0);

    // Fill the queue under a lookup stream; a 5th update waits for the forced pop.
    for (int i = 0; i < 60; i++) begin
      if (i == 4) begin
        check("full_upd_ready", ifc.upd_ready, 0);
        check("full_force", ifc.lookup_ready, 0);
        check("full_level", ifc.fifo_level, 4);
      end
      if (i == 5) begin
        check("after_pop_upd_ready", ifc.upd_ready, 1);
        check("after_pop_level", ifc.fifo_level, 3);
      end
      step(1'b0, 1'b1, pc_of($urandom_range(0, TS - 1)), i < 6,
           pc_of($urandom_range(48, 55)), 2'($urandom), 1'($urandom));
    end
    repeat (4) idle();
    check("full_drained", ifc.fifo_level, 0);

    // Random traffic with hazards on a small index range and rare clears.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, pc_of($urandom_range(0, 7)),
           $urandom_range(0, 9) < 4, pc_of($urandom_range(0, 7)), 2'($urandom), 1'($urandom));
    end

    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
    wait_run("resweep_len");

    // Clear with two queued updates, a lookup in the clear cycle and a discarded update.
    step(1'b0, 1'b1, pc_of(100), 1'b1, pc_of(10), 2'b01, 1'b1);
    step(1'b0, 1'b1, pc_of(101), 1'b1, pc_of(20), 2'b01, 1'b1);
    check("pre_clear_level", ifc.fifo_level, 2);
    step(1'b1, 1'b1, pc_of(10), 1'b1, pc_of(30), 2'b01, 1'b1);
    check("clear_pred_valid", ifc.pred_valid, 1);
    check("clear_level", ifc.fifo_level, 0);
    check("clear_init_busy", ifc.init_busy, 1);
    wait_run("clear_sweep_len");
    lookup(10);
    check("clear_idx10", ifc.pred_ctr, 1);
    lookup(20);
    check("clear_idx20", ifc.pred_ctr, 1);
    lookup(30);
    check("clear_idx30", ifc.pred_ctr, 1);
    lookup(5);
    check("clear_idx5", ifc.pred_ctr, 1);
    for (int i = 0; i < 6; i++) begin
      lookup($urandom_range(0, TS - 1));
      check("clear_rand", ifc.pred_ctr, 1);
    end

    // Reset asserted part-way through a sweep restarts it from index 0.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
    repeat (60) idle();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_run("rst_restart_len");
    for (int i = 0; i < 8; i++) begin
      lookup($urandom_range(0, TS - 1));
      check("rst_rand", ifc.pred_ctr, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
